lemming_ctrl_param: RTL and testbench
=====================================

// Module: lemming_ctrl_param
// PURPOSE
//   Parametrised single-lemming behaviour controller: walk/bump/fall/dig/splat Moore FSM.
//   Configurable fall-survival limit and optional finite dig budget.
//   Exported fall-cycle count and explicit splat flag for the game/score logic.
//   Sits between the level-terrain sampler (ground/bump/dig inputs) and the sprite/animation driver.
// PARAMETERS
//   FALL_LIMIT  20  max cycles in a fall that are survived; more than this -> splat on landing
//   DIG_BUDGET  0   max cycles of continuous digging; 0 = unlimited (dig until ground lost)
//   CNT_W       8   width of fall/dig counters; must hold max(FALL_LIMIT+1, DIG_BUDGET)
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   areset      in   1      reset, synchronous, active-high
//   bump_left   in   1      obstacle on left
//   bump_right  in   1      obstacle on right
//   ground      in   1      1 = ground under lemming
//   dig         in   1      dig command
//   walk_left   out  1      state WALK_L
//   walk_right  out  1      state WALK_R
//   aaah        out  1      state FALL_L or FALL_R
//   digging     out  1      state DIG_L or DIG_R
//   splat       out  1      state SPLAT (terminal)
//   fall_cnt    out  CNT_W  cycles spent in current/last fall, saturating at FALL_LIMIT+1
// BEHAVIOUR
//   - All outputs are registered Moore decodes of state; no input-to-output combinational path.
//   - Reset: areset=1 at a clk edge -> WALK_L, fall_cnt=0, dig counter=0.
//     Outputs after reset: walk_left=1, all other flags 0. Overrides every state, including SPLAT and mid-fall.
//   - States: WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT.
//   - WALK_x, evaluated in priority order:
//       1. ground=0 -> FALL_x, with fall_cnt<=1.
//       2. dig=1 -> DIG_x, with dig counter<=1.
//       3. A bump toward the walking direction (bump_left in WALK_L, bump_right in WALK_R) -> opposite WALK.
//          Both bumps asserted also reverses direction. A bump on the trailing side is ignored.
//       4. Otherwise hold.
//   - FALL_x:
//       - ground=0 -> stay; fall_cnt <= min(fall_cnt+1, FALL_LIMIT+1).
//       - ground=1 and fall_cnt>FALL_LIMIT -> SPLAT.
//       - ground=1 and fall_cnt<=FALL_LIMIT -> WALK_x, same direction as before the fall.
//       - bump and dig are ignored while falling.
//   - DIG_x:
//       - ground=0 -> FALL_x, with fall_cnt<=1. Ground loss beats budget expiry.
//       - Else, if DIG_BUDGET!=0 and dig counter==DIG_BUDGET -> WALK_x.
//       - Else stay, dig counter++.
//       - bump is ignored.
//   - SPLAT: absorbing; all outputs 0 except splat=1; leaves only via areset.
//   - fall_cnt holds its last value outside FALL states.
//     It is reloaded to 1 on each fall entry and is never allowed to wrap.
//   - A fall entered from DIG resumes walking in the dig direction on a survivable landing.
//   - Exactly one of walk_left/walk_right/aaah/digging/splat is 1 in every cycle after reset.
// TESTING
//   - Reset then idle, ground=1 -> walk_left=1 for every cycle.
//     Pulse bump_left 1 cycle -> walk_right=1 from the next edge.
//     Assert bump_left+bump_right together -> direction reverses again.
//   - WALK_R, ground=0 for exactly 20 cycles, then ground=1 (FALL_LIMIT=20):
//     aaah=1 for 20 cycles, fall_cnt=20, then walk_right=1, splat=0.
//   - Same sequence with 21 cycles of ground=0 -> splat=1 held.
//     100 cycles of random inputs -> still splat=1. areset 1 cycle -> walk_left=1.
//   - DIG_BUDGET=4, WALK_L, dig=1 one cycle -> digging=1 for 4 cycles, then walk_left=1.
//     Drop ground in dig cycle 2 -> aaah=1 next cycle, no walk_left in between.
//   - Fall for 300 cycles with CNT_W=8 -> fall_cnt saturates at 21, no wrap; landing -> splat=1.
//   - areset asserted mid-fall (fall_cnt=10) and mid-dig -> walk_left=1 and fall_cnt=0 on the next edge.
//     Check one-hot output invariant every cycle throughout all tests.

Source files
------------

// File: rtl/lemming_ctrl_param_if.sv
// Signal bundle between the terrain sampler, the lemming controller and the sprite driver.
// The master side drives terrain/command inputs; the slave (controller) drives state flags.
interface lemming_ctrl_param_if #(
    parameter int CNT_W = 8
);
    logic             bump_left;
    logic             bump_right;
    logic             ground;
    logic             dig;
    logic             walk_left;
    logic             walk_right;
    logic             aaah;
    logic             digging;
    logic             splat;
    logic [CNT_W-1:0] fall_cnt;

    modport master (
        output bump_left, bump_right, ground, dig,
        input  walk_left, walk_right, aaah, digging, splat, fall_cnt
    );

    modport slave (
        input  bump_left, bump_right, ground, dig,
        output walk_left, walk_right, aaah, digging, splat, fall_cnt
    );
endinterface

// File: rtl/lemming_ctrl_param.sv
// Single-lemming walk/bump/fall/dig/splat Moore controller with a configurable
// fall-survival limit, optional dig budget and a saturating fall-cycle counter.
module lemming_ctrl_param #(
    parameter int FALL_LIMIT = 20,
    parameter int DIG_BUDGET = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    lemming_ctrl_param_if.slave  lem
);

    localparam logic [2:0] ST_WALK_L = 3'd0;
    localparam logic [2:0] ST_WALK_R = 3'd1;
    localparam logic [2:0] ST_FALL_L = 3'd2;
    localparam logic [2:0] ST_FALL_R = 3'd3;
    localparam logic [2:0] ST_DIG_L  = 3'd4;
    localparam logic [2:0] ST_DIG_R  = 3'd5;
    localparam logic [2:0] ST_SPLAT  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FALL_SAT    = CNT_W'(FALL_LIMIT + 32'sd1);
    localparam logic [CNT_W-1:0] DIG_MAX     = CNT_W'(DIG_BUDGET);
    localparam logic             DIG_LIMITED = (DIG_BUDGET != 32'sd0);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] fall_cnt_r;
    logic [CNT_W-1:0] fall_cnt_nxt_s;
    logic [CNT_W-1:0] dig_cnt_r;
    logic [CNT_W-1:0] dig_cnt_nxt_s;
    logic             dir_right_s;
    logic             bump_ahead_s;
    logic [4:0]       flags_nxt_s;
    logic [4:0]       flags_r;

    // Direction is carried by the state encoding and survives falls and digs.
    always_comb begin
        dir_right_s  = (state_r == ST_WALK_R) || (state_r == ST_FALL_R) || (state_r == ST_DIG_R);
        bump_ahead_s = dir_right_s ? lem.bump_right : lem.bump_left;
    end

    // Next-state and counter update rules.
    always_comb begin
        state_nxt_s    = state_r;
        fall_cnt_nxt_s = fall_cnt_r;
        dig_cnt_nxt_s  = dig_cnt_r;
        case (state_r)
            ST_WALK_L, ST_WALK_R: begin
                if (!lem.ground) begin
                    state_nxt_s    = dir_right_s ? ST_FALL_R : ST_FALL_L;
                    fall_cnt_nxt_s = CNT_ONE;
                end else if (lem.dig) begin
                    state_nxt_s   = dir_right_s ? ST_DIG_R : ST_DIG_L;
                    dig_cnt_nxt_s = CNT_ONE;
                end else if (bump_ahead_s) begin
                    state_nxt_s = dir_right_s ? ST_WALK_L : ST_WALK_R;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_FALL_L, ST_FALL_R: begin
                if (!lem.ground) begin
                    state_nxt_s = state_r;
                    if (fall_cnt_r < FALL_SAT) begin
                        fall_cnt_nxt_s = fall_cnt_r + CNT_ONE;
                    end else begin
                        fall_cnt_nxt_s = fall_cnt_r;
                    end
                end else if (fall_cnt_r >= FALL_SAT) begin
                    state_nxt_s = ST_SPLAT;
                end else begin
                    state_nxt_s = dir_right_s ? ST_WALK_R : ST_WALK_L;
                end
            end
            ST_DIG_L, ST_DIG_R: begin
                if (!lem.ground) begin
                    state_nxt_s    = dir_right_s ? ST_FALL_R : ST_FALL_L;
                    fall_cnt_nxt_s = CNT_ONE;
                end else if (DIG_LIMITED && (dig_cnt_r == DIG_MAX)) begin
                    state_nxt_s = dir_right_s ? ST_WALK_R : ST_WALK_L;
                end else begin
                    state_nxt_s = state_r;
                    // Unlimited digging must not wrap the counter back to a budget match.
                    if (dig_cnt_r != CNT_MAX) begin
                        dig_cnt_nxt_s = dig_cnt_r + CNT_ONE;
                    end else begin
                        dig_cnt_nxt_s = dig_cnt_r;
                    end
                end
            end
            ST_SPLAT: begin
                state_nxt_s = ST_SPLAT;
            end
            default: begin
                // An illegal encoding parks in the terminal state until reset.
                state_nxt_s = ST_SPLAT;
            end
        endcase
    end

    // Moore decode of the upcoming state: {walk_left, walk_right, aaah, digging, splat}.
    always_comb begin
        flags_nxt_s = 5'b00000;
        case (state_nxt_s)
            ST_WALK_L:           flags_nxt_s = 5'b10000;
            ST_WALK_R:           flags_nxt_s = 5'b01000;
            ST_FALL_L, ST_FALL_R: flags_nxt_s = 5'b00100;
            ST_DIG_L, ST_DIG_R:   flags_nxt_s = 5'b00010;
            ST_SPLAT:            flags_nxt_s = 5'b00001;
            default:             flags_nxt_s = 5'b00001;
        endcase
    end

    // State, counters and output flags register together so outputs never see inputs combinationally.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r    <= ST_WALK_L;
            fall_cnt_r <= CNT_ZERO;
            dig_cnt_r  <= CNT_ZERO;
            flags_r    <= 5'b10000;
        end else begin
            state_r    <= state_nxt_s;
            fall_cnt_r <= fall_cnt_nxt_s;
            dig_cnt_r  <= dig_cnt_nxt_s;
            flags_r    <= flags_nxt_s;
        end
    end

    assign lem.walk_left  = flags_r[4];
    assign lem.walk_right = flags_r[3];
    assign lem.aaah       = flags_r[2];
    assign lem.digging    = flags_r[1];
    assign lem.splat      = flags_r[0];
    assign lem.fall_cnt   = fall_cnt_r;

endmodule

// File: tb/tb_lemming_ctrl_param.sv
// Scoreboard bench: two controllers (unlimited and 4-cycle dig budget) share stimulus;
// a behavioural model queues expected outputs and a negedge monitor compares them.
module tb_lemming_ctrl_param;

    localparam int LIM = 20;

    logic clk;
    logic areset;

    lemming_ctrl_param_if #(.CNT_W(8)) if0 ();
    lemming_ctrl_param_if #(.CNT_W(8)) if1 ();

    lemming_ctrl_param #(.FALL_LIMIT(LIM), .DIG_BUDGET(0), .CNT_W(8)) dut0 (
        .clk(clk), .areset(areset), .lem(if0.slave)
    );
    lemming_ctrl_param #(.FALL_LIMIT(LIM), .DIG_BUDGET(4), .CNT_W(8)) dut1 (
        .clk(clk), .areset(areset), .lem(if1.slave)
    );

    typedef struct packed {
        logic [4:0] f0;
        logic [7:0] c0;
        logic [4:0] f1;
        logic [7:0] c1;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: mode 0=walk 1=fall 2=dig 3=splat; dir 0=left 1=right.
    int m_mode[2];
    int m_dir[2];
    int m_fc[2];
    int m_dc[2];
    int budget[2] = '{0, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_flags(input int k);
        case (m_mode[k])
            0:       return (m_dir[k] != 0) ? 5'b01000 : 5'b10000;
            1:       return 5'b00100;
            2:       return 5'b00010;
            default: return 5'b00001;
        endcase
    endfunction

    task automatic model_step(input int k, input logic a, bl, br, g, d);
        if (a) begin
            m_mode[k] = 0; m_dir[k] = 0; m_fc[k] = 0; m_dc[k] = 0;
        end else if (m_mode[k] == 0) begin
            if (!g) begin
                m_mode[k] = 1; m_fc[k] = 1;
            end else if (d) begin
                m_mode[k] = 2; m_dc[k] = 1;
            end else if ((m_dir[k] == 0 && bl) || (m_dir[k] == 1 && br)) begin
                m_dir[k] = 1 - m_dir[k];
            end
        end else if (m_mode[k] == 1) begin
            if (!g) m_fc[k] = (m_fc[k] + 1 > LIM + 1) ? LIM + 1 : m_fc[k] + 1;
            else if (m_fc[k] > LIM) m_mode[k] = 3;
            else m_mode[k] = 0;
        end else if (m_mode[k] == 2) begin
            if (!g) begin
                m_mode[k] = 1; m_fc[k] = 1;
            end else if (budget[k] != 0 && m_dc[k] == budget[k]) begin
                m_mode[k] = 0;
            end else begin
                m_dc[k] = m_dc[k] + 1;
            end
        end
    endtask

    task automatic step(input logic a, bl, br, g, d);
        exp_t e;
        areset = a;
        if0.bump_left = bl; if0.bump_right = br; if0.ground = g; if0.dig = d;
        if1.bump_left = bl; if1.bump_right = br; if1.ground = g; if1.dig = d;
        @(posedge clk);
        model_step(0, a, bl, br, g, d);
        model_step(1, a, bl, br, g, d);
        e.f0 = model_flags(0); e.c0 = 8'(m_fc[0]);
        e.f1 = model_flags(1); e.c1 = 8'(m_fc[1]);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic fall(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic check(input string name, input logic [4:0] act_f, input logic [7:0] act_c,
                         input logic [4:0] exp_f, input logic [7:0] exp_c);
        total++;
        if (act_f !== exp_f) begin
            bad++;
            $display("FAIL %s flags t=%0t actual=%b required=%b", name, $time, act_f, exp_f);
        end
        total++;
        if (act_c !== exp_c) begin
            bad++;
            $display("FAIL %s fall_cnt t=%0t actual=%0d required=%0d", name, $time, act_c, exp_c);
        end
        total++;
        if (!$onehot(act_f)) begin
            bad++;
            $display("FAIL %s onehot t=%0t actual=%b required=exactly one bit", name, $time, act_f);
        end
    endtask

    // Monitor: outputs are valid every cycle after each stimulus edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("dut0", {if0.walk_left, if0.walk_right, if0.aaah, if0.digging, if0.splat},
                  if0.fall_cnt, e.f0, e.c0);
            check("dut1", {if1.walk_left, if1.walk_right, if1.aaah, if1.digging, if1.splat},
                  if1.fall_cnt, e.f1, e.c1);
        end
    end

    initial begin
        areset = 1'b1;
        if0.bump_left = 1'b0; if0.bump_right = 1'b0; if0.ground = 1'b1; if0.dig = 1'b0;
        if1.bump_left = 1'b0; if1.bump_right = 1'b0; if1.ground = 1'b1; if1.dig = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Survivable 20-cycle fall, then a fatal 21-cycle fall.
        fall(20);
        idle(3);
        fall(21);
        idle(1);
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Dig budget expiry, and ground loss during the dig.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Long fall saturates the counter.
        fall(300);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-fall and mid-dig.
        fall(10);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) == 0));

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
